// File: rtl/point_stream_tx.sv
// Host-side driver for the geometry core: serializes a 4-point frame as 2-bit beats,
// reassembles and checks the serial Max bytes, and latches the second-stage results.
module point_stream_tx #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] frame_x,
  input  logic [31:0] frame_y,
  output logic [1:0]  Din,
  output logic        in_valid,
  input  logic        ready,
  input  logic [1:0]  Max,
  input  logic        out_valid,
  input  logic        out_valid_SecondStage,
  input  logic [7:0]  Center_of_MassX,
  input  logic [7:0]  Center_of_MassY,
  input  logic [8:0]  LongestSide,
  input  logic [1:0]  TriangleType,
  input  logic [1:0]  ForthPoint,
  output logic [31:0] max_word,
  output logic [3:0]  max_err,
  output logic [7:0]  res_cx,
  output logic [7:0]  res_cy,
  output logic [8:0]  res_side,
  output logic [1:0]  res_tri,
  output logic [1:0]  res_fourth,
  output logic        frame_done,
  output logic        err_timeout
);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, SEND, COLLECT, WAIT_RES, DONE} state_t;
  state_t state, state_d;

  logic [31:0]   fx, fy;
  logic [1:0]    p, k;
  logic [2:0]    b, b_d;
  logic [WW-1:0] wcnt;
  logic          tmo, abort;
  logic [4:0]    base;
  logic [7:0]    px, py, pmax, byte_in;
  logic [15:0]   pt;

  assign base    = {p, 3'b000};
  assign px      = fx[base +: 8];
  assign py      = fy[base +: 8];
  assign pmax    = (px >= py) ? px : py;
  assign pt      = {py, px};
  // the 4th beat completes the byte in the same cycle it is captured
  assign byte_in = {Max, max_word[base +: 6]};
  assign tmo     = (wcnt == WW'(TIMEOUT - 1));
  assign b_d     = (state == SEND) ? b + 3'd1 : 3'd0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    abort   = 1'b0;
    case (state)
      IDLE:     if (load_valid && load_ready) state_d = WAIT_RDY;
      WAIT_RDY: if (ready) state_d = SEND;
                else if (tmo) abort = 1'b1;
      SEND:     if (b == 3'd7) state_d = COLLECT;
      COLLECT:  if (out_valid && k == 2'd3) state_d = (p == 2'd3) ? WAIT_RES : WAIT_RDY;
                else if (tmo) abort = 1'b1;
      WAIT_RES: if (out_valid_SecondStage) state_d = DONE;
                else if (tmo) abort = 1'b1;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_ready  <= 1'b0;
      frame_done  <= 1'b0;
      in_valid    <= 1'b0;
      Din         <= 2'd0;
      b           <= 3'd0;
      k           <= 2'd0;
      p           <= 2'd0;
      wcnt        <= '0;
      fx          <= 32'd0;
      fy          <= 32'd0;
      max_word    <= 32'd0;
      max_err     <= 4'd0;
      err_timeout <= 1'b0;
      res_cx      <= 8'd0;
      res_cy      <= 8'd0;
      res_side    <= 9'd0;
      res_tri     <= 2'd0;
      res_fourth  <= 2'd0;
    end else begin
      load_ready <= (state_d == IDLE);
      frame_done <= (state_d == DONE);
      in_valid   <= (state_d == SEND);
      Din        <= (state_d == SEND) ? pt[{b_d, 1'b0} +: 2] : 2'd0;
      b          <= b_d;
      wcnt       <= (state_d != state) ? '0 : wcnt + WW'(1);
      if (abort) err_timeout <= 1'b1;
      case (state)
        IDLE: if (state_d == WAIT_RDY) begin
          fx          <= frame_x;
          fy          <= frame_y;
          p           <= 2'd0;
          k           <= 2'd0;
          max_word    <= 32'd0;
          max_err     <= 4'd0;
          err_timeout <= 1'b0;
          res_cx      <= 8'd0;
          res_cy      <= 8'd0;
          res_side    <= 9'd0;
          res_tri     <= 2'd0;
          res_fourth  <= 2'd0;
        end
        COLLECT: if (out_valid) begin
          max_word[{p, k, 1'b0} +: 2] <= Max;
          k <= k + 2'd1;
          if (k == 2'd3) begin
            max_err[p] <= (byte_in != pmax);
            if (p != 2'd3) p <= p + 2'd1;
          end
        end
        WAIT_RES: if (out_valid_SecondStage) begin
          res_cx     <= Center_of_MassX;
          res_cy     <= Center_of_MassY;
          res_side   <= LongestSide;
          res_tri    <= TriangleType;
          res_fourth <= ForthPoint;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_point_stream_tx.sv
// Bench for point_stream_tx: behavioural core model drives ready/Max/results, checks
// serial beats, reassembled max bytes, error flags, timeout and reset behaviour.
module tb_point_stream_tx;
  logic        clk = 0, rst = 1, load_valid = 0, ready = 0, out_valid = 0, osv = 0;
  logic [31:0] frame_x = 0, frame_y = 0;
  logic [1:0]  Max = 0, tri_i = 0, fourth_i = 0;
  logic [7:0]  cx_i = 0, cy_i = 0;
  logic [8:0]  side_i = 0;
  logic        load_ready, in_valid, frame_done, err_timeout;
  logic [1:0]  Din, res_tri, res_fourth;
  logic [31:0] max_word;
  logic [3:0]  max_err;
  logic [7:0]  res_cx, res_cy;
  logic [8:0]  res_side;

  int n_checks = 0, n_fail = 0, fd_cnt = 0;

  point_stream_tx #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .frame_x(frame_x), .frame_y(frame_y), .Din(Din), .in_valid(in_valid), .ready(ready),
    .Max(Max), .out_valid(out_valid), .out_valid_SecondStage(osv),
    .Center_of_MassX(cx_i), .Center_of_MassY(cy_i), .LongestSide(side_i),
    .TriangleType(tri_i), .ForthPoint(fourth_i), .max_word(max_word), .max_err(max_err),
    .res_cx(res_cx), .res_cy(res_cy), .res_side(res_side), .res_tri(res_tri),
    .res_fourth(res_fourth), .frame_done(frame_done), .err_timeout(err_timeout));

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] fx, fy;
    logic [3:0]  bad_mask;
    logic [31:0] bad_bytes;
    logic [7:0]  cx, cy;
    logic [8:0]  side;
    logic [1:0]  tri_t, fourth;
    logic [31:0] exp_word;
    logic [3:0]  exp_err;
    bit          preloaded, hold_next, inject;
  } frame_t;

  frame_t vec[3];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // core returns max(X,Y) unless told to corrupt that point
  function automatic frame_t model(input frame_t f);
    frame_t m = f;
    logic [7:0] x, y, mx, s;
    m.exp_word = 0;
    m.exp_err  = 0;
    for (int i = 0; i < 4; i++) begin
      x  = f.fx[8*i +: 8];
      y  = f.fy[8*i +: 8];
      mx = (x >= y) ? x : y;
      s  = f.bad_mask[i] ? f.bad_bytes[8*i +: 8] : mx;
      m.exp_word[8*i +: 8] = s;
      m.exp_err[i] = (s != mx);
    end
    return m;
  endfunction

  task automatic run_frame(input frame_t f, input int abort_p, input frame_t nf);
    int fd0, lat;
    logic [7:0] xb, yb, mx, sb;
    logic [1:0] eb;
    fd0 = fd_cnt;
    if (!f.preloaded) begin
      lat = 0;
      while (load_ready !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      chk("load_ready_idle", load_ready, 1);
      frame_x = f.fx; frame_y = f.fy; load_valid = 1;
      @(negedge clk);
      load_valid = 0;
    end
    chk("load_ready_busy", load_ready, 0);
    chk("load_clears", {max_word, max_err, err_timeout, res_cx, res_side}, 0);
    for (int p = 0; p < 4; p++) begin
      xb = f.fx[8*p +: 8];
      yb = f.fy[8*p +: 8];
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ready = 1;
      @(negedge clk);
      ready = 0;
      for (int bt = 0; bt < 8; bt++) begin
        if (bt > 0) @(negedge clk);
        chk("in_valid_beat", in_valid, 1);
        eb = (bt < 4) ? 2'((xb >> (2*bt)) & 8'h3) : 2'((yb >> (2*(bt-4))) & 8'h3);
        chk("din_beat", Din, eb);
        if (p == abort_p && bt == 5) begin
          rst = 1; out_valid = 0;
          @(negedge clk);
          chk("abort_in_valid", {in_valid, Din}, 0);
          chk("abort_outputs", {load_ready, max_word, max_err, frame_done, err_timeout,
                                res_cx, res_cy, res_side, res_tri, res_fourth}, 0);
          rst = 0;
          @(negedge clk);
          chk("abort_load_ready", load_ready, 1);
          chk("abort_no_done", fd_cnt - fd0, 0);
          return;
        end
        if (f.inject) begin out_valid = 1; Max = 2'($urandom); end
      end
      @(negedge clk);
      out_valid = 0;
      chk("in_valid_len", {in_valid, Din}, 0);
      mx = (xb >= yb) ? xb : yb;
      sb = f.bad_mask[p] ? f.bad_bytes[8*p +: 8] : mx;
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        out_valid = 1; Max = sb[2*k +: 2];
        @(negedge clk);
        out_valid = 0;
      end
      chk("max_err_bit", max_err[p], sb != mx);
      chk("max_byte", max_word[8*p +: 8], sb);
    end
    repeat ($urandom_range(0, 4)) @(negedge clk);
    chk("no_early_done", frame_done, 0);
    osv = 1; cx_i = f.cx; cy_i = f.cy; side_i = f.side; tri_i = f.tri_t; fourth_i = f.fourth;
    if (f.hold_next) begin load_valid = 1; frame_x = nf.fx; frame_y = nf.fy; end
    @(negedge clk);
    osv = 0; cx_i = 8'($urandom); cy_i = 8'($urandom); side_i = 9'($urandom);
    chk("frame_done", frame_done, 1);
    chk("results", {res_cx, res_cy, res_side, res_tri, res_fourth},
        {f.cx, f.cy, f.side, f.tri_t, f.fourth});
    chk("max_word", max_word, f.exp_word);
    chk("max_err", max_err, f.exp_err);
    @(negedge clk);
    chk("done_pulse_end", frame_done, 0);
    chk("idle_load_ready", load_ready, 1);
    chk("done_count", fd_cnt - fd0, 1);
    chk("results_hold", {res_cx, res_cy, res_side}, {f.cx, f.cy, f.side});
    if (f.hold_next) begin
      @(negedge clk);
      chk("held_load_taken", load_ready, 0);
      load_valid = 0;
    end
  endtask

  initial begin
    frame_t f, dummy;
    int first;
    bit iv_seen;
    int fd0;

    vec[0] = '{fx:32'h0000000A, fy:32'h00000014, bad_mask:4'b0000, bad_bytes:32'h0,
               cx:8'd1, cy:8'd2, side:9'd3, tri_t:2'd0, fourth:2'd3,
               exp_word:32'h00000014, exp_err:4'b0000, preloaded:0, hold_next:0, inject:0};
    vec[1] = '{fx:32'hFF141E0A, fy:32'hFF280514, bad_mask:4'b0000, bad_bytes:32'h0,
               cx:8'd20, cy:8'd21, side:9'd35, tri_t:2'd1, fourth:2'd2,
               exp_word:32'hFF281E14, exp_err:4'b0000, preloaded:0, hold_next:1, inject:0};
    vec[2] = '{fx:32'hFF141E0A, fy:32'hFF280514, bad_mask:4'b0010, bad_bytes:32'h00001F00,
               cx:8'd7, cy:8'd9, side:9'd300, tri_t:2'd2, fourth:2'd1,
               exp_word:32'hFF281F14, exp_err:4'b0010, preloaded:1, hold_next:0, inject:1};
    dummy = vec[0];

    repeat (3) @(negedge clk);
    chk("reset_outputs", {load_ready, in_valid, Din, max_word, max_err, frame_done, err_timeout}, 0);
    chk("reset_results", {res_cx, res_cy, res_side, res_tri, res_fourth}, 0);
    rst = 0;
    @(negedge clk);
    chk("load_ready_after_reset", load_ready, 1);

    rst = 1; load_valid = 1; frame_x = 32'h12345678;
    @(negedge clk);
    rst = 0; load_valid = 0;
    @(negedge clk);
    chk("reset_beats_load", load_ready, 1);

    for (int i = 0; i < 3; i++) run_frame(vec[i], 4, vec[(i + 1) % 3]);

    // ready never comes: wait-state timeout
    frame_x = 32'h01020304; frame_y = 32'h05060708; load_valid = 1;
    @(negedge clk);
    load_valid = 0;
    first = -1; iv_seen = 0; fd0 = fd_cnt;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1 && first < 0) begin
        first = i;
        chk("timeout_load_ready", load_ready, 1);
      end
      if (in_valid === 1'b1) iv_seen = 1;
    end
    chk("timeout_cycle", first, 255);
    chk("timeout_sticky", err_timeout, 1);
    chk("timeout_idle", load_ready, 1);
    chk("timeout_no_done", fd_cnt - fd0, 0);
    chk("timeout_no_beats", iv_seen, 0);

    run_frame(vec[1], 2, dummy);
    f = vec[1]; f.hold_next = 0;
    run_frame(f, 4, dummy);

    for (int r = 0; r < 6; r++) begin
      f.fx = $urandom; f.fy = (r == 0) ? f.fx : $urandom;
      f.bad_mask  = (r % 2 == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      f.bad_bytes = $urandom;
      f.cx = 8'($urandom); f.cy = 8'($urandom); f.side = 9'($urandom);
      f.tri_t = 2'($urandom); f.fourth = 2'($urandom);
      f.preloaded = 0; f.hold_next = 0; f.inject = (r % 3 == 2);
      run_frame(model(f), 4, dummy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
